// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
//   Bundle between the raster/test-pattern generator and the DVI/TMDS encoder.
//   The clock (CK) and reset (SR) are plain ports on the modules.
//
//   Signals
//     CKE_i    shared clock enable, one pixel per enabled cycle
//     PAT_i    pattern select: 00 bars, 01 ramp, 10 solid, 11 checker
//     SOLID_i  {R,G,B} colour for the solid pattern
//     DE_o     data enable (active video)
//     HD_o     horizontal sync
//     VD_o     vertical sync
//     DAT_*_o  pixel colour components
//     X_o/Y_o  active pixel column / line, 0 outside DE
//     FS_o     frame-start strobe
//
//   Modports
//     master   the generator: consumes control, drives video
//     slave    the encoder/control side: drives control, consumes video
// -----------------------------------------------------------------------------
interface video_timing_gen_if;
   logic        CKE_i;
   logic [1:0]  PAT_i;
   logic [23:0] SOLID_i;
   logic        DE_o;
   logic        HD_o;
   logic        VD_o;
   logic [7:0]  DAT_R_o;
   logic [7:0]  DAT_G_o;
   logic [7:0]  DAT_B_o;
   logic [9:0]  X_o;
   logic [9:0]  Y_o;
   logic        FS_o;

   modport master (
      input  CKE_i, PAT_i, SOLID_i,
      output DE_o, HD_o, VD_o, DAT_R_o, DAT_G_o, DAT_B_o, X_o, Y_o, FS_o
   );

   modport slave (
      output CKE_i, PAT_i, SOLID_i,
      input  DE_o, HD_o, VD_o, DAT_R_o, DAT_G_o, DAT_B_o, X_o, Y_o, FS_o
   );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   720x480p59.94 raster timing generator (DE/HD/VD) with a selectable
//   test-pattern RGB stream, feeding a DVI/TMDS encoder one pixel per enabled
//   clock.
//
//   Ports
//     CK   pixel clock
//     SR   synchronous reset, active-high, has priority over CKE_i
//     vif  video_timing_gen_if.master (CKE_i, PAT_i, SOLID_i in;
//          DE_o, HD_o, VD_o, DAT_R/G/B_o, X_o, Y_o, FS_o out)
//
//   All outputs are registered from the decode of the current (HCNT, VCNT),
//   so every output lags the counter state by exactly one enabled cycle and
//   all outputs are mutually aligned.
// -----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int unsigned H_ACT  = 720,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 62,
   parameter int unsigned H_BP   = 60,
   parameter int unsigned V_ACT  = 480,
   parameter int unsigned V_FP   = 9,
   parameter int unsigned V_SYNC = 6,
   parameter int unsigned V_BP   = 30,
   parameter logic        HS_POL = 1'b0,
   parameter logic        VS_POL = 1'b0
) (
   input  logic               CK,
   input  logic               SR,
   video_timing_gen_if.master vif
);

   localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int unsigned BAR_W   = H_ACT / 8;

   localparam logic [9:0] H_ACT_C   = 10'(H_ACT);
   localparam logic [9:0] H_SS_C    = 10'(H_ACT + H_FP);
   localparam logic [9:0] H_SE_C    = 10'(H_ACT + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_C   = 10'(V_ACT);
   localparam logic [9:0] V_SS_C    = 10'(V_ACT + V_FP);
   localparam logic [9:0] V_SE_C    = 10'(V_ACT + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);
   localparam logic [9:0] BAR_LAST_C = 10'(BAR_W - 1);

   localparam logic [1:0] PAT_BARS  = 2'b00;
   localparam logic [1:0] PAT_RAMP  = 2'b01;
   localparam logic [1:0] PAT_SOLID = 2'b10;

   // Raster state
   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [9:0]  bar_px_q, bar_px_d;    // pixel position inside the current bar
   logic [2:0]  bar_idx_q, bar_idx_d;  // which colour bar HCNT is in
   logic [1:0]  pat_q, pat_d;
   logic [23:0] solid_q, solid_d;

   // Output registers
   logic        de_q, de_d;
   logic        hd_q, hd_d;
   logic        vd_q, vd_d;
   logic [23:0] rgb_q, rgb_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        fs_q, fs_d;

   // Decode of the current counter state
   logic        frame_start;
   logic        active;
   logic        hsync;
   logic        vsync;
   logic        h_wrap;
   logic [1:0]  pat_eff;
   logic [23:0] solid_eff;
   logic [23:0] pix;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 24'hFFFFFF;  // white
         3'd1:    bar_colour = 24'hFFFF00;  // yellow
         3'd2:    bar_colour = 24'h00FFFF;  // cyan
         3'd3:    bar_colour = 24'h00FF00;  // green
         3'd4:    bar_colour = 24'hFF00FF;  // magenta
         3'd5:    bar_colour = 24'hFF0000;  // red
         3'd6:    bar_colour = 24'h0000FF;  // blue
         default: bar_colour = 24'h000000;  // black
      endcase
   endfunction

   assign frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   assign active      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign hsync       = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
   assign vsync       = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
   assign h_wrap      = (h_cnt_q == H_LAST_C);

   // The pattern is re-latched at (0,0); the first pixel of the frame must
   // already use the new selection, so bypass the latch on that cycle.
   assign pat_eff   = frame_start ? vif.PAT_i   : pat_q;
   assign solid_eff = frame_start ? vif.SOLID_i : solid_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      pix = 24'h000000;
      if (active) begin
         case (pat_eff)
            PAT_BARS:  pix = bar_colour(bar_idx_q);
            PAT_RAMP:  pix = {3{h_cnt_q[7:0]}};
            PAT_SOLID: pix = solid_eff;
            default:   pix = (h_cnt_q[3] ^ v_cnt_q[3]) ? 24'hFFFFFF : 24'h000000;
         endcase
      end
   end

   always_comb begin
      h_cnt_d   = h_cnt_q + 10'd1;
      v_cnt_d   = v_cnt_q;
      bar_px_d  = bar_px_q + 10'd1;
      bar_idx_d = bar_idx_q;
      pat_d     = pat_q;
      solid_d   = solid_q;

      if (h_wrap) begin
         h_cnt_d = 10'd0;
         v_cnt_d = (v_cnt_q == V_LAST_C) ? 10'd0 : v_cnt_q + 10'd1;
      end

      // Bar tracker follows HCNT: restarts with the line, steps every BAR_W
      // pixels. Past the last bar it keeps counting, harmless since RGB is
      // forced to zero outside active video.
      if (h_wrap) begin
         bar_px_d  = 10'd0;
         bar_idx_d = 3'd0;
      end else if (bar_px_q == BAR_LAST_C) begin
         bar_px_d  = 10'd0;
         bar_idx_d = bar_idx_q + 3'd1;
      end

      if (frame_start) begin
         pat_d   = vif.PAT_i;
         solid_d = vif.SOLID_i;
      end

      de_d  = active;
      hd_d  = hsync ? HS_POL : ~HS_POL;
      vd_d  = vsync ? VS_POL : ~VS_POL;
      rgb_d = pix;
      x_d   = active ? h_cnt_q : 10'd0;
      y_d   = active ? v_cnt_q : 10'd0;
      fs_d  = frame_start;
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge CK) begin
      if (SR) begin
         h_cnt_q   <= 10'd0;
         v_cnt_q   <= 10'd0;
         bar_px_q  <= 10'd0;
         bar_idx_q <= 3'd0;
         pat_q     <= PAT_BARS;
         solid_q   <= 24'h000000;
         de_q      <= 1'b0;
         hd_q      <= ~HS_POL;
         vd_q      <= ~VS_POL;
         rgb_q     <= 24'h000000;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         fs_q      <= 1'b0;
      end else if (vif.CKE_i) begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         bar_px_q  <= bar_px_d;
         bar_idx_q <= bar_idx_d;
         pat_q     <= pat_d;
         solid_q   <= solid_d;
         de_q      <= de_d;
         hd_q      <= hd_d;
         vd_q      <= vd_d;
         rgb_q     <= rgb_d;
         x_q       <= x_d;
         y_q       <= y_d;
         fs_q      <= fs_d;
      end
   end

   assign vif.DE_o    = de_q;
   assign vif.HD_o    = hd_q;
   assign vif.VD_o    = vd_q;
   assign vif.DAT_R_o = rgb_q[23:16];
   assign vif.DAT_G_o = rgb_q[15:8];
   assign vif.DAT_B_o = rgb_q[7:0];
   assign vif.X_o     = x_q;
   assign vif.Y_o     = y_q;
   assign vif.FS_o    = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Horizontal timing is the real 858-pixel line; the frame is shortened to
//   16 lines so whole frames fit in a short run. The reference model tracks a
//   single pixel index within the frame and derives every output from it with
//   plain arithmetic.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

   localparam int   H_ACT  = 720;
   localparam int   H_FP   = 16;
   localparam int   H_SYNC = 62;
   localparam int   H_BP   = 60;
   localparam int   V_ACT  = 12;
   localparam int   V_FP   = 1;
   localparam int   V_SYNC = 2;
   localparam int   V_BP   = 1;
   localparam logic HS_POL = 1'b0;
   localparam logic VS_POL = 1'b0;

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOT * V_TOT;

   localparam logic [23:0] BAR_TBL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   // {DE, HD, VD, RGB, X, Y, FS}
   localparam logic [47:0] RST_VEC = {1'b0, ~HS_POL, ~VS_POL, 24'h0, 10'd0, 10'd0, 1'b0};

   logic clk;
   logic sr;
   video_timing_gen_if vif ();

   video_timing_gen #(
      .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .CK  (clk),
      .SR  (sr),
      .vif (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   // Reference model state
   int          m_pos = 0;
   int          m_h   = 0;
   int          m_v   = 0;
   logic [1:0]  m_pat = 2'b00;
   logic [23:0] m_solid = 24'h0;
   logic [47:0] exp_vec = RST_VEC;

   // Monitors
   int ck_cnt = 0;
   int fs_rise_q[$];
   logic prev_fs = 1'b0;
   int de_run = 0, de_len = 0, de_rises = 0;
   logic prev_de = 1'b0;
   int hd_run = 0, hd_len = 0;
   int vd_run = 0, vd_len = 0;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, ck_cnt, got, exp);
      end
   endtask

   function automatic logic [47:0] out_vec();
      return {vif.DE_o, vif.HD_o, vif.VD_o, vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o,
              vif.X_o, vif.Y_o, vif.FS_o};
   endfunction

   function automatic logic [47:0] ref_out(input int h, input int v,
                                           input logic [1:0] pat, input logic [23:0] solid);
      logic        act, hs, vs;
      logic [23:0] rgb;
      logic [9:0]  x, y;
      act = (h < H_ACT) && (v < V_ACT);
      hs  = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
      vs  = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC);
      rgb = 24'h0;
      x   = 10'd0;
      y   = 10'd0;
      if (act) begin
         x = 10'(h);
         y = 10'(v);
         case (pat)
            2'b00:   rgb = BAR_TBL[h / (H_ACT / 8)];
            2'b01:   rgb = {3{8'(h % 256)}};
            2'b10:   rgb = solid;
            default: rgb = (((h / 8) + (v / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
         endcase
      end
      return {act, hs ? HS_POL : ~HS_POL, vs ? VS_POL : ~VS_POL, rgb, x, y,
              (h == 0) && (v == 0)};
   endfunction

   task automatic model_clock(input logic r, input logic cke);
      if (r) begin
         m_pos   = 0;
         m_pat   = 2'b00;
         exp_vec = RST_VEC;
      end else if (cke) begin
         m_h = m_pos % H_TOT;
         m_v = m_pos / H_TOT;
         if (m_pos == 0) begin
            m_pat   = vif.PAT_i;
            m_solid = vif.SOLID_i;
         end
         exp_vec = ref_out(m_h, m_v, m_pat, m_solid);
         m_pos   = (m_pos + 1) % FRAME;
      end
   endtask

   // One CK cycle: drive at the falling edge, sample 1 time unit after the
   // rising edge, advance the model and compare every output.
   task automatic step(input logic r, input logic cke);
      @(negedge clk);
      sr        = r;
      vif.CKE_i = cke;
      @(posedge clk);
      #1;
      model_clock(r, cke);
      check("px", out_vec(), exp_vec);

      if (vif.FS_o && !prev_fs) fs_rise_q.push_back(ck_cnt);
      prev_fs = vif.FS_o;
      if (vif.DE_o && !prev_de) de_rises++;
      prev_de = vif.DE_o;
      if (vif.DE_o) de_run++;
      else if (de_run != 0) begin de_len = de_run; de_run = 0; end
      if (vif.HD_o == HS_POL) hd_run++;
      else if (hd_run != 0) begin hd_len = hd_run; hd_run = 0; end
      if (vif.VD_o == VS_POL) vd_run++;
      else if (vd_run != 0) begin vd_len = vd_run; vd_run = 0; end
      ck_cnt++;
   endtask

   initial begin
      logic done_rst;
      int   post;
      logic cke;

      sr          = 1'b1;
      vif.CKE_i   = 1'b0;
      vif.PAT_i   = 2'b00;
      vif.SOLID_i = 24'h0;

      // Reset, then one cycle of reset with enable low (SR wins over CKE)
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      check("rst", out_vec(), RST_VEC);

      // Two frames at full enable. Frame A is bars; PAT_i switches to solid
      // mid-frame and must only take effect from frame B.
      fs_rise_q.delete();
      de_rises = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (i == 5 * H_TOT + 100) begin
            vif.PAT_i   = 2'b10;
            vif.SOLID_i = 24'h123456;
         end
         step(1'b0, 1'b1);
         if (i == 0)
            check("first_px", out_vec(), {1'b1, ~HS_POL, ~VS_POL, 24'hFFFFFF, 10'd0, 10'd0, 1'b1});
         if (i < FRAME && m_v == 10) begin
            case (m_h)
               89:  check("bar_x89",  48'({vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o}), 48'h0FFFFFF);
               90:  check("bar_x90",  48'({vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o}), 48'h0FFFF00);
               629: check("bar_x629", 48'({vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o}), 48'h00000FF);
               630: check("bar_x630", 48'({vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o}), 48'h0000000);
               720: check("blank_x720", 48'({vif.DE_o, vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o}), 48'h0);
               default: ;
            endcase
         end
         if (i >= FRAME && m_v == 3 && m_h == 300)
            check("solid_b", 48'({vif.DAT_R_o, vif.DAT_G_o, vif.DAT_B_o}), 48'h123456);
      end
      check("fs_period", 48'((fs_rise_q.size() >= 2) ? fs_rise_q[1] - fs_rise_q[0] : 0), 48'(FRAME));
      check("de_len",   48'(de_len),   48'(H_ACT));
      check("hd_len",   48'(hd_len),   48'(H_SYNC));
      check("vd_len",   48'(vd_len),   48'(V_SYNC * H_TOT));
      check("de_lines", 48'(de_rises), 48'(2 * V_ACT));

      // Enable toggling 1/0: outputs hold on the low cycles and one frame
      // takes twice as many CK cycles. Pattern changes randomly meanwhile.
      fs_rise_q.delete();
      for (int i = 0; i < 2 * FRAME + 2; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            vif.PAT_i   = 2'($urandom);
            vif.SOLID_i = 24'($urandom);
         end
         step(1'b0, (i % 2) == 0);
      end
      check("fs_ck_period", 48'((fs_rise_q.size() >= 2) ? fs_rise_q[1] - fs_rise_q[0] : 0),
            48'(2 * FRAME));

      // Random enable, random pattern changes and a reset at line 8, pixel 400.
      done_rst = 1'b0;
      post     = 0;
      for (int i = 0; i < 30000 && post < 1500; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            vif.PAT_i   = 2'($urandom);
            vif.SOLID_i = 24'($urandom);
         end
         if (!done_rst && m_pos == 8 * H_TOT + 400) begin
            step(1'b1, 1'($urandom));
            check("mid_rst", out_vec(), RST_VEC);
            done_rst = 1'b1;
            for (int k = 0; k < 16; k++) begin
               cke = (k == 15) ? 1'b1 : 1'($urandom);
               step(1'b0, cke);
               if (cke) begin
                  check("restart", 48'({vif.FS_o, vif.DE_o, vif.X_o, vif.Y_o}),
                        48'({1'b1, 1'b1, 10'd0, 10'd0}));
                  break;
               end
            end
         end else begin
            step(1'b0, $urandom_range(0, 3) != 0);
            if (done_rst) post++;
         end
      end
      check("mid_rst_seen", 48'(done_rst), 48'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
